// File: rtl/oq_sram_read_scheduler_if.sv
// Handshake/status bundle between the OQ SRAM read scheduler and its neighbours.
// master = scheduler side, slave = writer / SRAM read controller / port side.
interface oq_sram_read_scheduler_if #(
    parameter int NUM_QUEUES = 5,
    parameter int CNT_W      = 8
);
    logic                        wr_pkt_done;
    logic [NUM_QUEUES-1:0]       wr_pkt_oq;
    logic [NUM_QUEUES-1:0]       port_ready;
    logic                        rd_valid;
    logic                        rd_ack;
    logic                        rd_last;
    logic [NUM_QUEUES-1:0]       rd_grant;
    logic [NUM_QUEUES-1:0]       q_full;
    logic [NUM_QUEUES*CNT_W-1:0] pkt_count;
    logic                        overflow;

    modport master (
        input  wr_pkt_done, wr_pkt_oq, port_ready, rd_ack, rd_last,
        output rd_valid, rd_grant, q_full, pkt_count, overflow
    );

    modport slave (
        output wr_pkt_done, wr_pkt_oq, port_ready, rd_ack, rd_last,
        input  rd_valid, rd_grant, q_full, pkt_count, overflow
    );
endinterface

// File: rtl/oq_sram_read_scheduler.sv
// Round-robin, packet-granular SRAM read scheduler for the output queues.
// Optional: define OQ_SCHED_STATS_EN to add the served_total packet counter.
module oq_sram_read_scheduler #(
    parameter int NUM_QUEUES = 5,
    parameter int CNT_W      = 8,
    parameter int MAX_PKTS   = 255
) (
    input  logic clk,
    input  logic resetn,
`ifdef OQ_SCHED_STATS_EN
    output logic [31:0] served_total,
`endif
    oq_sram_read_scheduler_if.master bus
);
    localparam int PTR_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PKTS);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       rr_nxt;
    logic [PTR_W-1:0]       pick;
    logic                   found;
    logic                   sel_ok;
    logic                   done_pkt;
    logic [CNT_W-1:0]       cnt     [NUM_QUEUES];
    logic [CNT_W-1:0]       cnt_nxt [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]  inc, dec, sat, elig;

    assign sel_ok   = $onehot(bus.wr_pkt_oq);
    // rd_ack without an outstanding rd_valid is ignored
    assign done_pkt = (state == SERVE) & bus.rd_valid
                    & bus.rd_ack & bus.rd_last;
    assign rr_nxt   = (gnt_idx == PTR_W'(NUM_QUEUES - 1))
                    ? '0 : gnt_idx + PTR_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            inc[i]     = bus.wr_pkt_done & sel_ok & bus.wr_pkt_oq[i];
            dec[i]     = done_pkt & (gnt_idx == PTR_W'(i));
            sat[i]     = inc[i] & ~dec[i] & (cnt[i] == MAX_C);
            elig[i]    = (cnt[i] != '0) & bus.port_ready[i];
            cnt_nxt[i] = cnt[i];
            if (inc[i] & ~dec[i] & ~sat[i])
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            else if (dec[i] & ~inc[i])
                cnt_nxt[i] = cnt[i] - CNT_W'(1);
        end
    end

    // Closest eligible queue at or after rr_ptr, distance taken modulo NUM_QUEUES
    always_comb begin
        int best_d;
        int d;
        found  = 1'b0;
        pick   = '0;
        best_d = NUM_QUEUES;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            d = i - int'(rr_ptr);
            if (d < 0)
                d = d + NUM_QUEUES;
            if (elig[i] && d < best_d) begin
                best_d = d;
                pick   = PTR_W'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        bus.pkt_count = '0;
        for (int i = 0; i < NUM_QUEUES; i++)
            bus.pkt_count[i*CNT_W +: CNT_W] = cnt[i];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gnt_idx      <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_grant <= '0;
            bus.q_full   <= '0;
            bus.overflow <= 1'b0;
            for (int i = 0; i < NUM_QUEUES; i++)
                cnt[i] <= '0;
`ifdef OQ_SCHED_STATS_EN
            served_total <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                cnt[i]        <= cnt_nxt[i];
                bus.q_full[i] <= (cnt_nxt[i] == MAX_C);
            end
            if (bus.wr_pkt_done & (~sel_ok | (|sat)))
                bus.overflow <= 1'b1;
            unique case (state)
                IDLE: begin
                    bus.rd_valid <= 1'b0;
                    if (found) begin
                        state        <= SERVE;
                        gnt_idx      <= pick;
                        bus.rd_grant <= NUM_QUEUES'(1) << pick;
                    end else begin
                        bus.rd_grant <= '0;
                    end
                end
                SERVE: begin
                    if (done_pkt) begin
                        state        <= IDLE;
                        rr_ptr       <= rr_nxt;
                        bus.rd_valid <= 1'b0;
                        bus.rd_grant <= '0;
`ifdef OQ_SCHED_STATS_EN
                        served_total <= served_total + 32'd1;
`endif
                    end else begin
                        bus.rd_valid <= |(bus.port_ready & bus.rd_grant);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oq_sram_read_scheduler.sv
// Directed table-driven bench for oq_sram_read_scheduler.
// Cycle vectors plus hand sequences for stall, saturation and async reset.
module tb_oq_sram_read_scheduler;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    oq_sram_read_scheduler_if #(.NUM_QUEUES(5), .CNT_W(8)) bus ();

`ifdef OQ_SCHED_STATS_EN
    logic [31:0] served_total;
`endif

    oq_sram_read_scheduler #(
        .NUM_QUEUES(5), .CNT_W(8), .MAX_PKTS(255)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
`ifdef OQ_SCHED_STATS_EN
        .served_total (served_total),
`endif
        .bus    (bus.master)
    );

    typedef struct {
        logic        done;
        logic [4:0]  oq;
        logic [4:0]  pr;
        logic        ack;
        logic        last;
        logic        exp_valid;
        logic [4:0]  exp_grant;
        logic [39:0] exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic d, logic [4:0] oq, logic [4:0] pr,
                                logic a, logic l, logic v, logic [4:0] g,
                                logic [39:0] c, logic o);
        vec_t r;
        r.done = d; r.oq = oq; r.pr = pr; r.ack = a; r.last = l;
        r.exp_valid = v; r.exp_grant = g; r.exp_cnt = c; r.exp_ovf = o;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic d, logic [4:0] oq, logic [4:0] pr,
                         logic a, logic l);
        bus.wr_pkt_done = d;
        bus.wr_pkt_oq   = oq;
        bus.port_ready  = pr;
        bus.rd_ack      = a;
        bus.rd_last     = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'b0, 5'b0, 1'b0, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        drive(1'b0, 5'b0, 5'b0, 1'b0, 1'b0);
        // q0,q1,q3 one packet each, granted in order from rr=0
        tbl[0]  = mk(1, 5'b00001, 0, 0, 0, 0, 0,       40'h00_00_00_00_01, 0);
        tbl[1]  = mk(1, 5'b00010, 0, 0, 0, 0, 0,       40'h00_00_00_01_01, 0);
        tbl[2]  = mk(1, 5'b01000, 0, 0, 0, 0, 0,       40'h00_01_00_01_01, 0);
        tbl[3]  = mk(0, 0, 5'b01011, 0, 0, 0, 5'b00001, 40'h00_01_00_01_01, 0);
        tbl[4]  = mk(0, 0, 5'b01011, 0, 0, 1, 5'b00001, 40'h00_01_00_01_01, 0);
        tbl[5]  = mk(0, 0, 5'b01011, 1, 1, 0, 0,       40'h00_01_00_01_00, 0);
        tbl[6]  = mk(0, 0, 5'b01011, 0, 0, 0, 5'b00010, 40'h00_01_00_01_00, 0);
        tbl[7]  = mk(0, 0, 5'b01011, 0, 0, 1, 5'b00010, 40'h00_01_00_01_00, 0);
        tbl[8]  = mk(0, 0, 5'b01011, 1, 1, 0, 0,       40'h00_01_00_00_00, 0);
        tbl[9]  = mk(0, 0, 5'b01011, 0, 0, 0, 5'b01000, 40'h00_01_00_00_00, 0);
        tbl[10] = mk(0, 0, 5'b01011, 0, 0, 1, 5'b01000, 40'h00_01_00_00_00, 0);
        tbl[11] = mk(0, 0, 5'b01011, 1, 1, 0, 0,       40'h00_00_00_00_00, 0);
        tbl[12] = mk(0, 0, 5'b01011, 0, 0, 0, 0,       40'h00_00_00_00_00, 0);
        // three packets into q2 with its port not ready
        tbl[13] = mk(1, 5'b00100, 0, 0, 0, 0, 0,       40'h00_00_01_00_00, 0);
        tbl[14] = mk(1, 5'b00100, 0, 0, 0, 0, 0,       40'h00_00_02_00_00, 0);
        tbl[15] = mk(1, 5'b00100, 0, 0, 0, 0, 0,       40'h00_00_03_00_00, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,              40'h00_00_03_00_00, 0);
        tbl[17] = mk(0, 0, 5'b00100, 0, 0, 0, 5'b00100, 40'h00_00_03_00_00, 0);
        tbl[18] = mk(0, 0, 5'b00100, 0, 0, 1, 5'b00100, 40'h00_00_03_00_00, 0);
        tbl[19] = mk(0, 0, 5'b00100, 1, 1, 0, 0,       40'h00_00_02_00_00, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0,              40'h00_00_02_00_00, 0);
        // malformed selects
        tbl[21] = mk(1, 5'b00101, 0, 0, 0, 0, 0,       40'h00_00_02_00_00, 1);
        tbl[22] = mk(1, 5'b00000, 0, 0, 0, 0, 0,       40'h00_00_02_00_00, 1);

        do_reset();
        #1;
        chk("reset rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("reset rd_grant", 64'(bus.rd_grant), 64'd0);
        chk("reset pkt_count", 64'(bus.pkt_count), 64'd0);
        chk("reset q_full", 64'(bus.q_full), 64'd0);
        chk("reset overflow", 64'(bus.overflow), 64'd0);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].done, tbl[i].oq, tbl[i].pr, tbl[i].ack, tbl[i].last);
            step();
            chk($sformatf("v%0d rd_valid", i), 64'(bus.rd_valid), 64'(tbl[i].exp_valid));
            chk($sformatf("v%0d rd_grant", i), 64'(bus.rd_grant), 64'(tbl[i].exp_grant));
            chk($sformatf("v%0d pkt_count", i), 64'(bus.pkt_count), 64'(tbl[i].exp_cnt));
            chk($sformatf("v%0d overflow", i), 64'(bus.overflow), 64'(tbl[i].exp_ovf));
            chk($sformatf("v%0d q_full", i), 64'(bus.q_full), 64'd0);
        end
`ifdef OQ_SCHED_STATS_EN
        chk("served_total", 64'(served_total), 64'd4);
`endif

        // port_ready stall mid-packet on q1; q2 stays pending
        do_reset();
        drive(1, 5'b00010, 0, 0, 0); step();
        drive(1, 5'b00100, 0, 0, 0); step();
        drive(0, 0, 5'b00110, 0, 0); step();
        chk("stall grant", 64'(bus.rd_grant), 64'h02);
        step();
        chk("stall valid up", 64'(bus.rd_valid), 64'd1);
        drive(0, 0, 5'b00100, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("stall%0d valid", i), 64'(bus.rd_valid), 64'd0);
            chk($sformatf("stall%0d grant", i), 64'(bus.rd_grant), 64'h02);
        end
        drive(0, 0, 5'b00110, 0, 0); step();
        chk("resume valid", 64'(bus.rd_valid), 64'd1);
        drive(0, 0, 5'b00110, 1, 1); step();
        chk("resume done grant", 64'(bus.rd_grant), 64'd0);
        chk("resume done count", 64'(bus.pkt_count), 64'h00_00_01_00_00);
        drive(0, 0, 5'b00110, 0, 0); step();
        chk("next grant q2", 64'(bus.rd_grant), 64'h04);

        // saturation on q4
        do_reset();
        for (int i = 0; i < 255; i++) begin
            drive(1, 5'b10000, 0, 0, 0); step();
        end
        chk("sat count", 64'(bus.pkt_count), 64'hFF_00_00_00_00);
        chk("sat q_full", 64'(bus.q_full), 64'h10);
        chk("sat no ovf", 64'(bus.overflow), 64'd0);
        step();
        chk("over count", 64'(bus.pkt_count), 64'hFF_00_00_00_00);
        chk("over ovf", 64'(bus.overflow), 64'd1);
        drive(0, 0, 5'b10000, 0, 0); step();
        chk("q4 grant", 64'(bus.rd_grant), 64'h10);
        step();
        chk("q4 valid", 64'(bus.rd_valid), 64'd1);
        drive(1, 5'b10000, 5'b10000, 1, 1); step();
        chk("same-cycle count", 64'(bus.pkt_count), 64'hFF_00_00_00_00);
        chk("same-cycle q_full", 64'(bus.q_full), 64'h10);
        chk("same-cycle grant", 64'(bus.rd_grant), 64'd0);

        // async reset mid-packet on q2
        do_reset();
        drive(1, 5'b00100, 0, 0, 0); step();
        step();
        drive(0, 0, 5'b00100, 0, 0); step();
        step();
        drive(0, 0, 5'b00100, 1, 0); step();
        chk("mid valid", 64'(bus.rd_valid), 64'd1);
        chk("mid count", 64'(bus.pkt_count), 64'h00_00_02_00_00);
        drive(0, 0, 5'b00100, 0, 0);
        #2 resetn = 1'b0;
        #1;
        chk("async valid", 64'(bus.rd_valid), 64'd0);
        chk("async grant", 64'(bus.rd_grant), 64'd0);
        chk("async count", 64'(bus.pkt_count), 64'd0);
        chk("async ovf", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0); step();
        chk("post count", 64'(bus.pkt_count), 64'd0);
        chk("post grant", 64'(bus.rd_grant), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
